risc_loader: RTL and testbench
==============================

# risc_loader

Program-load sequencer placed between the tile pins and the `risc` core. It accepts a framed byte stream and writes the payload into the core's instruction memory via the `inst_we`/`inst_address`/`inst_data` port. It checks an 8-bit additive checksum, then releases the core with `cpu_run`. While loading, or after a failed load, the core is held stopped.

## Interface
Parameters:
- `ADDR_W`, 7: instruction-memory address width; maximum payload is 2^ADDR_W bytes.
- `DATA_W`, 8: byte width.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_valid`  in  1  an input byte is presented.
- `byte_data`  in  DATA_W  input byte.
- `byte_ready`  out  1  loader can accept a byte; a transfer happens on `byte_valid && byte_ready` at a rising edge.
- `halt_req`  in  1  stop the running core and return to IDLE.
- `inst_we`  out  1  instruction-memory write strobe, one cycle per payload byte.
- `inst_address`  out  ADDR_W  write address.
- `inst_data`  out  DATA_W  write data.
- `cpu_run`  out  1  1 = core may execute; 0 = core held stopped.
- `busy`  out  1  a frame is in progress (LEN, DATA, CSUM).
- `error`  out  1  last frame failed its checksum.

## Operation
- States:
  - IDLE: wait for sync.
  - LEN: length byte.
  - DATA: payload.
  - CSUM: checksum byte.
  - RUN: core executing.
  - ERROR: failed frame.
- `byte_ready`:
  - 1 in IDLE, LEN, DATA, CSUM and ERROR.
  - 0 in RUN.
  - Forced 0 while `rst` is high.
- IDLE:
  - Accepted byte equal to SYNC_BYTE → LEN.
  - Any other byte is dropped with no effect.
- LEN:
  - Accepted byte L sets the expected count N = L, except L = 0 gives N = 2^ADDR_W (128).
  - Clear address counter and checksum accumulator; → DATA.
- DATA:
  - Each accepted byte B is written to the current address; the address then increments.
  - Accumulator += B, modulo 2^DATA_W.
  - After the Nth byte → CSUM.
  - Address counter is ADDR_W+1 bits internally, so that N = 128 terminates correctly; only the low ADDR_W bits drive `inst_address`.
- CSUM:
  - Accepted byte equal to the accumulator → RUN.
  - Otherwise → ERROR.
- RUN:
  - `cpu_run` = 1.
  - `halt_req` → IDLE.
  - No bytes are accepted.
- ERROR:
  - `error` = 1.
  - SYNC_BYTE → LEN, and `error` clears on that transfer.
  - Other bytes are dropped.
  - `halt_req` has no effect.
- `halt_req` is ignored outside RUN.
- A SYNC_BYTE value received inside DATA or CSUM is treated as ordinary data; there is no in-frame resync.
- Memory contents are never cleared by the loader; a partial or failed load leaves already-written bytes in place.

## Timing
- Reset values:
  - state = IDLE.
  - `inst_we` = 0, `inst_address` = 0, `inst_data` = 0.
  - `cpu_run` = 0, `busy` = 0, `error` = 0.
- All outputs except `byte_ready` are registered. `byte_ready` is a decode of the current state.
- Payload write latency is 1 cycle: a byte accepted at edge k gives `inst_we` = 1 with its address and data during cycle k+1. Back-to-back bytes give a continuous `inst_we` burst.
- `cpu_run` rises in the cycle after a matching checksum is accepted.
- `cpu_run` falls in the cycle after `halt_req` is sampled high in RUN.
- `busy` is high from the cycle after SYNC is accepted until the cycle after the checksum byte is accepted.
- `rst` mid-frame aborts the frame:
  - Next state IDLE; `inst_we` low in the following cycle.
  - A write pending from the same edge is dropped.
- `byte_valid` may be held high across cycles. Each cycle with `byte_ready` high consumes one byte; there is no implicit hold.

## Structure
- Shared package `risc_pkg` holds:
  - The state enum (IDLE, LEN, DATA, CSUM, RUN, ERROR).
  - SYNC_BYTE default.
  - ADDR_W/DATA_W defaults shared with `risc`.
- A single flat module; no sub-module is warranted. Counter, accumulator and FSM together are about 150 lines.
- In `tt_um_risc`, `cpu_run` gates the core's active-low reset (core reset = `rst_n && cpu_run`), and the loader's `rst` = !`rst_n`.

## Test plan
- Load 3 bytes: stream A5, 03, 11, 22, 33, 66 → `inst_we` pulses at addresses 0/1/2 with 11/22/33; `cpu_run` = 1 one cycle after 66; `error` stays 0.
- Bad checksum: A5, 02, 10, 20, 31 → state ERROR, `error` = 1, `cpu_run` = 0. Then A5, 01, 7F, 7F → `error` clears on A5 and the load completes with `cpu_run` = 1.
- Length 0 means 128: A5, 00, then bytes 00..7F, then checksum C0 → 128 writes, last to address 7F; `cpu_run` = 1.
- Noise and halt: bytes 00, FF before A5 → no writes. After a good load, assert `halt_req` for one cycle → `cpu_run` = 0 next cycle, `byte_ready` = 1; bytes sent during RUN are not consumed.
- Reset mid-load: assert `rst` after the 2nd of 4 data bytes → all outputs 0 next cycle, state IDLE. A subsequent fresh frame loads correctly.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the risc core and its program loader.
// Holds the loader state encoding plus the default widths and frame marker
// that both the core and the loader are built with.
package risc_pkg;

    localparam int          RISC_ADDR_W    = 7;
    localparam int          RISC_DATA_W    = 8;
    localparam logic [7:0]  RISC_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/risc_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   byte_valid / byte_data / byte_ready : framed input byte stream
//   inst_we / inst_address / inst_data  : instruction-memory write port
// The slave modport is the loader side; the master modport is the side that
// supplies bytes and observes the memory writes.
interface risc_loader_if
    import risc_pkg::*;
#(
    parameter int ADDR_W = RISC_ADDR_W,
    parameter int DATA_W = RISC_DATA_W
);
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              byte_ready;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] inst_data;

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output inst_we,
        output inst_address,
        output inst_data
    );

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  inst_we,
        input  inst_address,
        input  inst_data
    );
endinterface

// File: rtl/risc_loader.sv
// Program-load sequencer between the tile pins and the risc core.
// Accepts a frame  SYNC, LEN, payload[N], CSUM  on the byte stream, writes the
// payload into instruction memory starting at address 0, checks an 8-bit
// additive checksum and then releases the core.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : byte stream in, instruction-memory write port out
//   halt_req   : stop the running core and return to IDLE
//   cpu_run    : 1 = core may execute
//   busy       : a frame is in progress
//   error      : last frame failed its checksum
module risc_loader
    import risc_pkg::*;
#(
    parameter int              ADDR_W    = RISC_ADDR_W,
    parameter int              DATA_W    = RISC_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(RISC_SYNC_BYTE)
) (
    input  logic           clk,
    input  logic           rst,
    risc_loader_if.slave   bus,
    input  logic           halt_req,
    output logic           cpu_run,
    output logic           busy,
    output logic           error
);

    localparam int            CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // A length byte of zero stands for a full memory of 2^ADDR_W bytes.
    localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_next;
    // One bit wider than the address so a full-memory load can reach N.
    logic [CNT_W-1:0]  addr_cnt;
    logic [CNT_W-1:0]  n_len;
    logic [DATA_W-1:0] acc;
    logic              xfer;
    logic              is_sync;
    logic              last_data;

    assign bus.byte_ready = !rst && (state != ST_RUN);
    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign is_sync        = (bus.byte_data == SYNC_BYTE);
    assign last_data      = ((addr_cnt + CNT_ONE) == n_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (xfer && is_sync) state_next = ST_LEN;
            ST_LEN:   if (xfer) state_next = ST_DATA;
            ST_DATA:  if (xfer && last_data) state_next = ST_CSUM;
            ST_CSUM:  if (xfer) state_next = (bus.byte_data == acc) ? ST_RUN : ST_ERROR;
            ST_RUN:   if (halt_req) state_next = ST_IDLE;
            ST_ERROR: if (xfer && is_sync) state_next = ST_LEN;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state the loader is actually in during the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.inst_we      <= 1'b0;
            bus.inst_address <= '0;
            bus.inst_data    <= '0;
            cpu_run          <= 1'b0;
            busy             <= 1'b0;
            error            <= 1'b0;
            addr_cnt         <= '0;
            n_len            <= '0;
            acc              <= '0;
        end else begin
            bus.inst_we <= xfer && (state == ST_DATA);
            cpu_run     <= (state_next == ST_RUN);
            busy        <= (state_next == ST_LEN) || (state_next == ST_DATA) ||
                           (state_next == ST_CSUM);
            error       <= (state_next == ST_ERROR);

            if (xfer && (state == ST_LEN)) begin
                n_len    <= (bus.byte_data == '0) ? LEN_MAX : CNT_W'(bus.byte_data);
                addr_cnt <= '0;
                acc      <= '0;
            end

            if (xfer && (state == ST_DATA)) begin
                bus.inst_address <= addr_cnt[ADDR_W-1:0];
                bus.inst_data    <= bus.byte_data;
                addr_cnt         <= addr_cnt + CNT_ONE;
                acc              <= acc + bus.byte_data;
            end
        end
    end

endmodule

// File: tb/tb_risc_loader.sv
// Self-checking bench for risc_loader: directed frames from the test plan
// followed by randomized frames, checked against a frame-level model.
module tb_risc_loader;
    import risc_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    logic halt_req;
    logic cpu_run;
    logic busy;
    logic error;

    risc_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    risc_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_BYTE(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .halt_req (halt_req),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [128];
    logic [7:0] dut_mem [128];
    int         wr_count = 0;
    int         last_addr = -1;

    // Memory image as seen through the DUT's write port.
    always @(negedge clk) begin
        if (bus.inst_we === 1'b1) begin
            dut_mem[bus.inst_address] = bus.inst_data;
            last_addr = int'(bus.inst_address);
            wr_count++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    // Presents one byte and returns just after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        int tries;
        tries = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && tries < 40) begin
            tick();
            tries++;
        end
        if (tries >= 40) check("ready_timeout", 32'(bus.byte_ready), 32'd1);
        else tick();
    endtask

    task automatic mem_check(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 128; i++) if (dut_mem[i] !== ref_mem[i]) diffs++;
        check(tag, 32'(diffs), 32'd0);
    endtask

    task automatic halt_core();
        idle();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    // Sends a whole frame with optional idle gaps; the model updates the
    // reference memory and returns the byte count it expects to be written.
    task automatic send_frame(input logic [7:0] len_byte, input logic [7:0] pl[$],
                              input bit corrupt, input int gap_pct, output int n_exp);
        int sum;
        logic [7:0] csum;
        sum = 0;
        foreach (pl[i]) sum += int'(pl[i]);
        csum = 8'(sum);
        if (corrupt) csum = 8'(sum + 1 + int'($urandom_range(0, 254)));
        n_exp = (len_byte == 8'h00) ? 128 : int'(len_byte);
        send_byte(SYNC);
        send_byte(len_byte);
        foreach (pl[i]) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                idle();
                tick();
            end
            send_byte(pl[i]);
            ref_mem[i % 128] = pl[i];
        end
        send_byte(csum);
        idle();
    endtask

    initial begin
        logic [7:0] pl[$];
        int n_exp;
        int wr_before;
        bit corrupt;
        int len;

        foreach (ref_mem[i]) begin
            ref_mem[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end
        rst = 1'b1;
        halt_req = 1'b0;
        idle();
        tick(); tick(); tick();

        // Reset state
        check("rst_inst_we", 32'(bus.inst_we), 32'd0);
        check("rst_inst_address", 32'(bus.inst_address), 32'd0);
        check("rst_inst_data", 32'(bus.inst_data), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_byte_ready", 32'(bus.byte_ready), 32'd1);

        // Noise before sync is dropped
        send_byte(8'h00);
        send_byte(8'hFF);
        idle();
        tick();
        check("noise_writes", 32'(wr_count), 32'd0);
        check("noise_busy", 32'(busy), 32'd0);

        // Directed 3-byte load with write latency and burst checks
        send_byte(SYNC);
        check("sync_busy", 32'(busy), 32'd1);
        send_byte(8'h03);
        send_byte(8'h11);
        check("w0_we", 32'(bus.inst_we), 32'd1);
        check("w0_addr", 32'(bus.inst_address), 32'd0);
        check("w0_data", 32'(bus.inst_data), 32'h11);
        send_byte(8'h22);
        check("w1_we", 32'(bus.inst_we), 32'd1);
        check("w1_addr", 32'(bus.inst_address), 32'd1);
        check("w1_data", 32'(bus.inst_data), 32'h22);
        send_byte(8'h33);
        check("w2_addr", 32'(bus.inst_address), 32'd2);
        check("w2_data", 32'(bus.inst_data), 32'h33);
        check("csum_wait_run", 32'(cpu_run), 32'd0);
        send_byte(8'h66);
        check("load3_run", 32'(cpu_run), 32'd1);
        check("load3_error", 32'(error), 32'd0);
        check("load3_busy", 32'(busy), 32'd0);
        check("load3_writes", 32'(wr_count), 32'd3);
        ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33;
        mem_check("load3_mem");

        // Bytes presented during RUN are not consumed
        bus.byte_valid = 1'b1;
        bus.byte_data  = SYNC;
        tick();
        check("run_byte_ready", 32'(bus.byte_ready), 32'd0);
        tick(); tick();
        check("run_no_writes", 32'(wr_count), 32'd3);
        check("run_busy", 32'(busy), 32'd0);
        check("run_still", 32'(cpu_run), 32'd1);

        // Halt
        halt_core();
        check("halt_cpu_run", 32'(cpu_run), 32'd0);
        check("halt_byte_ready", 32'(bus.byte_ready), 32'd1);

        // Bad checksum, halt ignored in ERROR, then recovery
        pl = '{8'h10, 8'h20};
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h31);
        idle();
        ref_mem[0] = 8'h10; ref_mem[1] = 8'h20;
        check("bad_error", 32'(error), 32'd1);
        check("bad_cpu_run", 32'(cpu_run), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        halt_core();
        tick();
        check("err_halt_ignored", 32'(error), 32'd1);
        check("err_byte_ready", 32'(bus.byte_ready), 32'd1);
        send_byte(8'h42);
        check("err_noise_kept", 32'(error), 32'd1);
        send_byte(SYNC);
        check("err_clear_on_sync", 32'(error), 32'd0);
        send_byte(8'h01); send_byte(8'h7F); send_byte(8'h7F);
        idle();
        ref_mem[0] = 8'h7F;
        check("recover_run", 32'(cpu_run), 32'd1);
        check("recover_error", 32'(error), 32'd0);
        mem_check("recover_mem");

        // Length byte 0 loads the full 128-byte memory
        halt_core();
        pl.delete();
        for (int i = 0; i < 128; i++) pl.push_back(8'(i));
        wr_before = wr_count;
        send_frame(8'h00, pl, 1'b0, 0, n_exp);
        check("full_writes", 32'(wr_count - wr_before), 32'(n_exp));
        check("full_last_addr", 32'(last_addr), 32'h7F);
        check("full_run", 32'(cpu_run), 32'd1);
        mem_check("full_mem");

        // Reset in the middle of a frame drops the pending write
        halt_core();
        send_byte(SYNC); send_byte(8'h04); send_byte(8'hDE); send_byte(8'hAD);
        check("pre_rst_we", 32'(bus.inst_we), 32'd1);
        bus.byte_data = 8'hBE;
        rst = 1'b1;
        tick();
        check("mrst_inst_we", 32'(bus.inst_we), 32'd0);
        check("mrst_inst_address", 32'(bus.inst_address), 32'd0);
        check("mrst_inst_data", 32'(bus.inst_data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_cpu_run", 32'(cpu_run), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        idle();
        rst = 1'b0;
        ref_mem[0] = 8'hDE; ref_mem[1] = 8'hAD;
        tick(); tick();
        check("mrst_writes_stop", 32'(bus.inst_we), 32'd0);
        mem_check("mrst_mem");
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame(8'h04, pl, 1'b0, 0, n_exp);
        check("fresh_run", 32'(cpu_run), 32'd1);
        mem_check("fresh_mem");

        // Randomized frames with noise, gaps and corrupted checksums
        for (int f = 0; f < 10; f++) begin
            if (cpu_run === 1'b1) halt_core();
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
                logic [7:0] nb;
                nb = 8'($urandom);
                if (nb == SYNC) nb = 8'h5A;
                send_byte(nb);
            end
            idle();
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            pl.delete();
            for (int i = 0; i < ((len == 0) ? 128 : len); i++) pl.push_back(8'($urandom));
            corrupt = ($urandom_range(0, 9) < 3);
            wr_before = wr_count;
            send_frame(8'(len), pl, corrupt, 30, n_exp);
            check("rnd_writes", 32'(wr_count - wr_before), 32'(n_exp));
            check("rnd_cpu_run", 32'(cpu_run), 32'(!corrupt));
            check("rnd_error", 32'(error), 32'(corrupt));
            check("rnd_busy", 32'(busy), 32'd0);
            mem_check("rnd_mem");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
